ahb_lite_sram_slave: RTL

//  AHB-Lite subordinate (slave): the responder end of the bus that the AHB-Lite master drives.

---
 rtl/ahb_lite_sram_slave.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite subordinate backed by a word-addressed SRAM.
// Supports byte/halfword/word access, fixed wait states and a two-cycle ERROR response.
`timescale 1ns/1ps
module ahb_lite_sram_slave #(
  parameter int DATAWIDTH   = 32,
  parameter int ADDRWIDTH   = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [1:0]           HTRANS,
  input  logic [DATAWIDTH-1:0] HWDATA,
  input  logic                 HREADY,
  output logic [DATAWIDTH-1:0] HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LANES = DATAWIDTH / 8;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [ADDRWIDTH-1:0] DEPTH_LIM = ADDRWIDTH'(MEM_DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, new_idx;
  logic [1:0]           off_q, size_q;
  logic                 write_q;
  logic [DATAWIDTH-1:0] rdata_q, rdata_d, mem_word, merged, lane_mask;
  logic [LANES-1:0]     lane_en;
  logic                 accept, addr_err, commit, capture;
  logic                 unused_ok;
  logic [DATAWIDTH-1:0] mem [MEM_DEPTH];

  assign unused_ok = ^{HBURST, HTRANS[0]};
  assign accept    = HSEL & HREADY & HTRANS[1];
  assign new_idx   = HADDR[IDX_W+1:2];
  assign addr_err  = ({2'b00, HADDR[ADDRWIDTH-1:2]} >= DEPTH_LIM) | (HSIZE > 3'd2) |
                     ((HSIZE == 3'd1) & HADDR[0]) | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

  always_comb begin
    lane_en   = '0;
    lane_mask = '0;
    case (size_q)
      2'd0:    lane_en[off_q] = 1'b1;
      2'd1:    lane_en[{off_q[1], 1'b0} +: 2] = 2'b11;
      default: lane_en = '1;
    endcase
    for (int i = 0; i < LANES; i++) lane_mask[8*i +: 8] = {8{lane_en[i]}};
  end

  // A read whose address phase overlaps a committing write to the same word sees the merged word.
  assign mem_word = mem[idx_q];
  assign merged   = (mem_word & ~lane_mask) | (HWDATA & lane_mask);
  assign commit   = (state_q == ST_DATA) & HREADY & write_q;
  assign rdata_d  = (commit && (idx_q == new_idx)) ? merged : mem[new_idx];

  always_ff @(posedge HCLK) begin
    if (commit && !HRESET) mem[idx_q] <= merged;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        idx_q   <= new_idx;
        off_q   <= HADDR[1:0];
        size_q  <= HSIZE[1:0];
        write_q <= HWRITE;
        rdata_q <= rdata_d;
      end
    end
  end

  // New address phases are only taken in states where this slave drives HREADYOUT high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (state_q)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q >= WS) state_d = ST_DATA;
        else             cnt_d = cnt_q + 4'd1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ST_ERR2;
      end
      default: begin
        if (state_q == ST_DATA) HRDATA = rdata_q;
        if (state_q == ST_ERR2) HRESP  = 1'b1;
        if (HREADY) begin
          capture = accept;
          if (!accept)        state_d = ST_IDLE;
          else if (addr_err)  state_d = ST_ERR1;
          else if (WS != 4'd0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'd1;
          end else            state_d = ST_DATA;
        end
      end
    endcase
  end

endmodule
